reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 122 ++++++++++++
 tb/tb_reg_dump_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Scans every register of a register file in id order and offers each value
// downstream over a valid/ready handshake, accumulating XOR and sum checksums.
module reg_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic [ADDR_W-1:0]        readRegId,
  input  logic [DATA_W-1:0]        readVal,
  output logic [DATA_W-1:0]        dumpData,
  output logic [ADDR_W-1:0]        dumpId,
  output logic                     dumpValid,
  input  logic                     dumpReady,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        xorSum,
  output logic [DATA_W+ADDR_W-1:0] addSum
);

  typedef enum logic [1:0] {IDLE, FETCH, OFFER, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ID = ADDR_W'(NUM_REGS - 1);

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          ptr_q, ptr_d;
  logic [DATA_W-1:0]          dump_data_q, dump_data_d;
  logic [ADDR_W-1:0]          dump_id_q, dump_id_d;
  logic                       dump_valid_q, dump_valid_d;
  logic [DATA_W-1:0]          xor_sum_q, xor_sum_d;
  logic [DATA_W+ADDR_W-1:0]   add_sum_q, add_sum_d;
  logic                       accept;

  // abort outranks the handshake so an aborted word never reaches the sums
  assign accept = (state_q == OFFER) && dump_valid_q && dumpReady && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      dump_data_q  <= '0;
      dump_id_q    <= '0;
      dump_valid_q <= 1'b0;
      xor_sum_q    <= '0;
      add_sum_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dump_data_q  <= dump_data_d;
      dump_id_q    <= dump_id_d;
      dump_valid_q <= dump_valid_d;
      xor_sum_q    <= xor_sum_d;
      add_sum_q    <= add_sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = abort ? IDLE : OFFER;
      OFFER: begin
        if (abort)       state_d = IDLE;
        else if (accept) state_d = (ptr_q == LAST_ID) ? FINISH : FETCH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    dump_data_d  = dump_data_q;
    dump_id_d    = dump_id_q;
    dump_valid_d = dump_valid_q;
    xor_sum_d    = xor_sum_q;
    add_sum_d    = add_sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d     = '0;
          xor_sum_d = '0;
          add_sum_d = '0;
        end
      end
      FETCH: begin
        if (!abort) begin
          dump_data_d  = readVal;
          dump_id_d    = ptr_q;
          dump_valid_d = 1'b1;
        end
      end
      OFFER: begin
        if (abort) begin
          dump_valid_d = 1'b0;
        end else if (accept) begin
          xor_sum_d    = xor_sum_q ^ dump_data_q;
          add_sum_d    = add_sum_q + (DATA_W+ADDR_W)'(dump_data_q);
          dump_valid_d = 1'b0;
          // pointer parks on the last id rather than wrapping
          if (ptr_q != LAST_ID) ptr_d = ptr_q + 1'b1;
        end
      end
      default: dump_valid_d = 1'b0;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == FINISH);
    readRegId = ptr_q;
    dumpData  = dump_data_q;
    dumpId    = dump_id_q;
    dumpValid = dump_valid_q;
    xorSum    = xor_sum_q;
    addSum    = add_sum_q;
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full scans, stalls, abort and mid-scan reset,
// with a behavioural register file answering readRegId.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, dumpReady;
  logic [2:0]  readRegId, dumpId;
  logic [7:0]  readVal, dumpData, xorSum;
  logic        dumpValid, busy, done;
  logic [10:0] addSum;
  logic [7:0]  rf [0:7];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign readVal = rf[readRegId];

  reg_dump_reader #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .readRegId(readRegId), .readVal(readVal),
    .dumpData(dumpData), .dumpId(dumpId), .dumpValid(dumpValid), .dumpReady(dumpReady),
    .busy(busy), .done(done), .xorSum(xorSum), .addSum(addSum)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; abort = 1'b1; dumpReady = 1'b1;
    step; step;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_over_start: busy=%b want 0", busy); end
    start = 1'b0; abort = 1'b0; dumpReady = 1'b0;
    step;
    reset = 1'b0;
    tests++;
    if (readRegId !== 3'd0) begin fails++; $display("FAIL rst_readRegId: got %h want 0", readRegId); end
    tests++;
    if (dumpData !== 8'h00) begin fails++; $display("FAIL rst_dumpData: got %h want 00", dumpData); end
    tests++;
    if (dumpId !== 3'd0) begin fails++; $display("FAIL rst_dumpId: got %h want 0", dumpId); end
    tests++;
    if (dumpValid !== 1'b0) begin fails++; $display("FAIL rst_dumpValid: got %b want 0", dumpValid); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done); end
    tests++;
    if (xorSum !== 8'h00 || addSum !== 11'h000) begin
      fails++; $display("FAIL rst_sums: xor=%h add=%h want 00/000", xorSum, addSum);
    end
    step;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_after_rst: busy=%b want 0", busy); end
  endtask

  task automatic test_all_ff;
    int cyc, n;
    for (int i = 0; i < 8; i++) rf[i] = 8'hFF;
    dumpReady = 1'b1;
    start = 1'b1; step; start = 1'b0;
    cyc = 1; n = 0;
    tests++;
    if (busy !== 1'b1 || readRegId !== 3'd0) begin
      fails++; $display("FAIL ff_start: busy=%b id=%h want 1/0", busy, readRegId);
    end
    while (!done && cyc < 60) begin
      if (dumpValid && dumpReady) begin
        tests++;
        if (dumpId !== 3'(n) || dumpData !== 8'hFF) begin
          fails++; $display("FAIL ff_word%0d: id=%h data=%h want %h/FF", n, dumpId, dumpData, 3'(n));
        end
        n++;
      end
      step; cyc++;
    end
    tests++;
    if (done !== 1'b1 || cyc != 17) begin
      fails++; $display("FAIL ff_done_cycle: done=%b cycle=%0d want 1 at 17", done, cyc);
    end
    tests++;
    if (n != 8) begin fails++; $display("FAIL ff_word_count: got %0d want 8", n); end
    tests++;
    if (xorSum !== 8'h00 || addSum !== 11'h7F8) begin
      fails++; $display("FAIL ff_sums: xor=%h add=%h want 00/7F8", xorSum, addSum);
    end
    step;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL ff_back_idle: done=%b busy=%b want 0/0", done, busy);
    end
    step; step;
    tests++;
    if (xorSum !== 8'h00 || addSum !== 11'h7F8) begin
      fails++; $display("FAIL ff_sums_hold: xor=%h add=%h want 00/7F8", xorSum, addSum);
    end
  endtask

  task automatic test_incr;
    int cyc, n;
    for (int i = 0; i < 8; i++) rf[i] = 8'(i + 1);
    dumpReady = 1'b1;
    start = 1'b1; step; start = 1'b0;
    cyc = 1; n = 0;
    tests++;
    if (xorSum !== 8'h00 || addSum !== 11'h000) begin
      fails++; $display("FAIL inc_sums_cleared: xor=%h add=%h want 00/000", xorSum, addSum);
    end
    while (!done && cyc < 60) begin
      if (dumpValid && dumpReady) begin
        tests++;
        if (dumpId !== 3'(n) || dumpData !== 8'(n + 1)) begin
          fails++; $display("FAIL inc_word%0d: id=%h data=%h want %h/%h", n, dumpId, dumpData, 3'(n), 8'(n + 1));
        end
        n++;
      end
      step; cyc++;
    end
    tests++;
    if (done !== 1'b1 || cyc != 17 || n != 8) begin
      fails++; $display("FAIL inc_done: done=%b cycle=%0d words=%0d want 1/17/8", done, cyc, n);
    end
    tests++;
    if (xorSum !== 8'h08 || addSum !== 11'h024) begin
      fails++; $display("FAIL inc_sums: xor=%h add=%h want 08/024", xorSum, addSum);
    end
    step;
  endtask

  task automatic test_stall;
    int cyc, n, stall;
    for (int i = 0; i < 8; i++) rf[i] = 8'(8'h10 + i);
    dumpReady = 1'b1;
    start = 1'b1; step; start = 1'b0;
    cyc = 1; n = 0; stall = 0;
    while (!done && cyc < 80) begin
      if (dumpValid && dumpId == 3'd2 && stall < 3) begin
        dumpReady = 1'b0;
        tests++;
        if (dumpData !== 8'h12) begin
          fails++; $display("FAIL stall_hold%0d: data=%h want 12", stall, dumpData);
        end
        stall++;
      end else begin
        dumpReady = 1'b1;
      end
      if (dumpValid && dumpReady) begin
        tests++;
        if (dumpId !== 3'(n) || dumpData !== 8'(8'h10 + n)) begin
          fails++; $display("FAIL stall_word%0d: id=%h data=%h want %h/%h", n, dumpId, dumpData, 3'(n), 8'(8'h10 + n));
        end
        n++;
      end
      step; cyc++;
    end
    dumpReady = 1'b1;
    tests++;
    if (stall != 3) begin fails++; $display("FAIL stall_valid_held: held %0d cycles want 3", stall); end
    tests++;
    if (done !== 1'b1 || cyc != 20 || n != 8) begin
      fails++; $display("FAIL stall_done: done=%b cycle=%0d words=%0d want 1/20/8", done, cyc, n);
    end
    tests++;
    if (xorSum !== 8'h00 || addSum !== 11'h09C) begin
      fails++; $display("FAIL stall_sums: xor=%h add=%h want 00/09C", xorSum, addSum);
    end
    step;
  endtask

  task automatic test_abort;
    int cyc, n, dones;
    for (int i = 0; i < 8; i++) rf[i] = 8'(i + 1);
    dumpReady = 1'b1;
    start = 1'b1; step; start = 1'b0;
    cyc = 1; n = 0; dones = 0;
    while (cyc < 60 && !(dumpValid && dumpId == 3'd4)) begin
      if (dumpValid) n++;
      if (done) dones++;
      step; cyc++;
    end
    tests++;
    if (dumpValid !== 1'b1 || dumpData !== 8'h05 || n != 4) begin
      fails++; $display("FAIL abort_reach_id4: valid=%b data=%h words=%0d want 1/05/4", dumpValid, dumpData, n);
    end
    abort = 1'b1; step; abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || dumpValid !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL abort_idle: busy=%b valid=%b done=%b want 0/0/0", busy, dumpValid, done);
    end
    tests++;
    if (xorSum !== 8'h04 || addSum !== 11'h00A) begin
      fails++; $display("FAIL abort_partial_sums: xor=%h add=%h want 04/00A", xorSum, addSum);
    end
    for (int i = 0; i < 4; i++) begin
      if (done) dones++;
      step;
    end
    tests++;
    if (dones != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    abort = 1'b1; step; abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || xorSum !== 8'h04 || addSum !== 11'h00A) begin
      fails++; $display("FAIL abort_in_idle: busy=%b xor=%h add=%h want 0/04/00A", busy, xorSum, addSum);
    end
    start = 1'b1; abort = 1'b1; step; start = 1'b0; abort = 1'b0;
    cyc = 1; n = 0;
    tests++;
    if (busy !== 1'b1 || readRegId !== 3'd0 || xorSum !== 8'h00 || addSum !== 11'h000) begin
      fails++; $display("FAIL abort_restart: busy=%b id=%h xor=%h add=%h want 1/0/00/000", busy, readRegId, xorSum, addSum);
    end
    while (!done && cyc < 60) begin
      if (dumpValid && dumpReady) begin
        tests++;
        if (dumpId !== 3'(n) || dumpData !== 8'(n + 1)) begin
          fails++; $display("FAIL restart_word%0d: id=%h data=%h want %h/%h", n, dumpId, dumpData, 3'(n), 8'(n + 1));
        end
        n++;
      end
      step; cyc++;
    end
    tests++;
    if (done !== 1'b1 || cyc != 17 || n != 8 || xorSum !== 8'h08 || addSum !== 11'h024) begin
      fails++; $display("FAIL restart_done: done=%b cycle=%0d words=%0d xor=%h add=%h want 1/17/8/08/024",
                        done, cyc, n, xorSum, addSum);
    end
    step;
  endtask

  task automatic test_reset_mid;
    int cyc, n, dones;
    for (int i = 0; i < 8; i++) rf[i] = 8'(8'h20 + i);
    dumpReady = 1'b1;
    start = 1'b1; step; start = 1'b0;
    cyc = 1; dones = 0;
    while (cyc < 60 && !(busy && !dumpValid && readRegId == 3'd5)) begin
      start = (cyc == 3);
      if (done) dones++;
      step; cyc++;
    end
    start = 1'b0;
    tests++;
    if (cyc != 11) begin fails++; $display("FAIL mid_fetch5_cycle: got %0d want 11", cyc); end
    reset = 1'b1; step; reset = 1'b0;
    tests++;
    if (readRegId !== 3'd0 || dumpData !== 8'h00 || dumpId !== 3'd0 || dumpValid !== 1'b0) begin
      fails++; $display("FAIL mid_rst_dump: id=%h data=%h did=%h valid=%b want 0/00/0/0", readRegId, dumpData, dumpId, dumpValid);
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || xorSum !== 8'h00 || addSum !== 11'h000 || dones != 0) begin
      fails++; $display("FAIL mid_rst_ctrl: busy=%b done=%b xor=%h add=%h pulses=%0d want 0/0/00/000/0",
                        busy, done, xorSum, addSum, dones);
    end
    start = 1'b1; step; start = 1'b0;
    cyc = 1; n = 0;
    while (!done && cyc < 60) begin
      start = (cyc == 5 || cyc == 6);
      if (dumpValid && dumpReady) begin
        tests++;
        if (dumpId !== 3'(n) || dumpData !== 8'(8'h20 + n)) begin
          fails++; $display("FAIL mid_word%0d: id=%h data=%h want %h/%h", n, dumpId, dumpData, 3'(n), 8'(8'h20 + n));
        end
        n++;
      end
      step; cyc++;
    end
    if (done) dones++;
    tests++;
    if (cyc != 17 || n != 8) begin
      fails++; $display("FAIL mid_rescan: cycle=%0d words=%0d want 17/8", cyc, n);
    end
    start = 1'b1; step; start = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_in_finish: busy=%b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      if (done) dones++;
      step;
    end
    tests++;
    if (dones != 1) begin fails++; $display("FAIL mid_done_count: got %0d want 1", dones); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    reset = 1'b1; start = 1'b0; abort = 1'b0; dumpReady = 1'b0;
    test_reset;
    test_all_ff;
    test_incr;
    test_stall;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
